speaker_serializer: RTL and testbench
=====================================

SPEAKER_SERIALIZER -- requirements
Module: speaker_serializer

Interface
REQ-001 The block SHALL have parameter `DIV_LOG2`, default 2: the clk/mclk ratio is 2^DIV_LOG2, so `clk` 100 MHz gives mclk 25 MHz.
REQ-002 The block SHALL have input `clk`, 1 bit: the crystal clock; all flops are clocked on its rising edge.
REQ-003 The block SHALL have input `rst`, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have input `enable`, 1 bit: 0 mutes the serial data; the clocks keep running.
REQ-005 The block SHALL have input `audio_left`, 16 bits: left sample, two's complement, from the note generator.
REQ-006 The block SHALL have input `audio_right`, 16 bits: right sample, two's complement.
REQ-007 The block SHALL have output `audio_mclk`, 1 bit: DAC master clock.
REQ-008 The block SHALL have output `audio_lrck`, 1 bit: word select; 0 = left, 1 = right.
REQ-009 The block SHALL have output `audio_sck`, 1 bit: serial bit clock.
REQ-010 The block SHALL have output `audio_sdin`, 1 bit: serial data, I2S format, MSB first.
REQ-011 The block SHALL have output `sample_ack`, 1 bit: one-cycle pulse marking that a new sample pair has been captured.

Function
REQ-012 The block SHALL have one free-running up-counter `cnt` of width DIV_LOG2+8 (default 10 bits), incrementing every clk and wrapping from all-ones to 0; one wrap is one frame.
- Frame length at default: 1024 clk.
REQ-013 Each clock output SHALL be driven directly from one counter flop bit, with no combinational logic, so it is glitch-free:
- `audio_mclk` = cnt[D-1]
- `audio_sck` = cnt[D+2]
- `audio_lrck` = cnt[D+7]
- where D = DIV_LOG2.
REQ-014 The clock ratios SHALL be: sck = mclk/8, lrck = mclk/256, giving 32 sck periods per frame.
- Each sck period is one bit slot.
- Slot index = cnt[D+7:D+3], range 0..31.
REQ-015 On the clk edge where cnt is all-ones, the block SHALL capture {audio_left, audio_right} into a 32-bit holding register.
- If `enable` = 0 on that edge, it SHALL capture 32'h0 instead.
- Input changes at any other time SHALL NOT affect the frame in progress.
REQ-016 `sample_ack` SHALL be registered and high for exactly the one cycle in which cnt == 0, i.e. the cycle after capture; it pulses once per frame.
REQ-017 Slot mapping SHALL follow I2S with a one-bit delay:
- Slot 0 carries the previous frame's right[0].
- Slots 1..16 carry left[15..0].
- Slots 17..31 carry right[15..1].
- right[0] of the current frame SHALL appear in slot 0 of the following frame.
REQ-018 `audio_sdin` SHALL be a flop that updates only on the clk edge where cnt[D+2:0] is all-ones.
- It therefore changes together with the sck falling edge.
- It is stable for the whole sck-high half-period.
REQ-019 The block SHALL implement the serializer as a 32-bit shift register loaded from the holding register at the frame boundary, plus a 1-bit carry flop holding right[0] for the next frame's slot 0.
- No mux over the slot index is required.
REQ-020 When `enable` is deasserted mid-frame, the current frame SHALL complete unchanged; muting takes effect from the next captured frame.
REQ-021 The first frame after reset SHALL output all-zero data, because the holding register and carry flop reset to 0.

Reset
REQ-022 While rst == 0 at a clk edge, the block SHALL clear to 0: cnt, holding register, shift register, carry flop, `audio_sdin` and `sample_ack`.
- All outputs therefore read 0 in the cycle after the edge.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with no completion of the current word.
- After release, cnt SHALL restart at 0 and the timing in REQ-012..REQ-018 SHALL hold from that point.
REQ-024 The block SHALL have no asynchronous reset path.

Verification
REQ-025 Reset check: hold rst=0 for 5 cycles, then release -> all outputs 0 during reset; afterwards mclk period 4 clk, sck period 32 clk, lrck period 1024 clk, lrck low for the first 512 cycles.
REQ-026 Data check: apply enable=1, left=16'hA500, right=16'h5A5B before the first cnt==1023 -> sampling sdin on sck rising edges gives:
- slots 1..16 of the next frame = A500;
- slots 17..31 = 5A5B>>1;
- slot 0 of the following frame = 1.
REQ-027 Mid-frame change: change left to 16'h1234 at cnt==300 -> the current frame still shows A500; the next frame shows 1234.
REQ-028 Mute: drop enable at cnt==700 -> the current frame is unaffected; the next frame's sdin is all 0 except slot 0, which carries the prior right[0]; mclk, sck and lrck keep toggling.
REQ-029 Mid-frame reset: assert rst at cnt==500 for 1 cycle -> the next cycle shows all outputs 0 and cnt 0, and the first frame after reset is all-zero data.
REQ-030 sample_ack: run 4 frames -> exactly 4 single-cycle pulses, spaced 1024 cycles apart, each coincident with cnt==0.

Source files
------------

// File: rtl/speaker_serializer.sv
// speaker_serializer: I2S serializer with counter-derived mclk/sck/lrck for an audio DAC
// Ports:
//   clk          crystal clock, all flops on its rising edge
//   rst          synchronous active-low reset
//   enable       0 mutes data captured at the next frame boundary
//   audio_left   left sample, two's complement
//   audio_right  right sample, two's complement
//   audio_mclk   DAC master clock, clk / 2^DIV_LOG2
//   audio_sck    bit clock, mclk / 8
//   audio_lrck   word select (0 = left, 1 = right), mclk / 256
//   audio_sdin   serial data, I2S, MSB first with one-bit delay
//   sample_ack   one-cycle pulse after a sample pair is captured
module speaker_serializer #(
  parameter int DIV_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_ack
);
  localparam int W = DIV_LOG2 + 8;
  logic [W-1:0] cnt;
  logic [31:0]  hold;
  logic [31:0]  shift;
  logic         carry;
  logic         bit_edge;
  logic         frame_end;
  logic         first_slot;
  assign bit_edge   = &cnt[DIV_LOG2+2:0];
  assign frame_end  = &cnt;
  assign first_slot = cnt[DIV_LOG2+7:DIV_LOG2+3] == 5'd0;
  assign audio_mclk = cnt[DIV_LOG2-1];
  assign audio_sck  = cnt[DIV_LOG2+2];
  assign audio_lrck = cnt[DIV_LOG2+7];
  // Slot 0 is fed from carry (previous word's right[0]); the end of slot 0
  // loads the shifter from hold so slots 1..31 carry hold[31:1].
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      hold       <= '0;
      shift      <= '0;
      carry      <= 1'b0;
      audio_sdin <= 1'b0;
      sample_ack <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      sample_ack <= frame_end;
      if (frame_end) hold <= enable ? {audio_left, audio_right} : 32'h0;
      if (bit_edge) begin
        if (frame_end) begin
          audio_sdin <= carry;
        end else if (first_slot) begin
          audio_sdin <= hold[31];
          shift      <= {hold[30:0], 1'b0};
          carry      <= hold[0];
        end else begin
          audio_sdin <= shift[31];
          shift      <= {shift[30:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_speaker_serializer.sv
// tb_speaker_serializer: scoreboard bench for speaker_serializer framing, data slots, mute and reset
module tb_speaker_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] audio_left = 16'hA500;
  logic [15:0] audio_right = 16'h5A5B;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_ack;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  bit          started = 1'b0;
  logic        sck_prev = 1'b0;
  bit          q[$];

  speaker_serializer #(.DIV_LOG2(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .audio_left(audio_left), .audio_right(audio_right),
    .audio_mclk(audio_mclk), .audio_lrck(audio_lrck), .audio_sck(audio_sck),
    .audio_sdin(audio_sdin), .sample_ack(sample_ack)
  );

  always #5 clk = ~clk;

  // cycles elapsed since the last reset edge
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input bit s0, input logic [31:0] w);
    q.push_back(s0);
    for (int i = 31; i >= 1; i--) q.push_back(w[i]);
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      bad++;
      $display("FAIL wait_cyc: got %0d want %0d", cyc, n);
    end
  endtask

  // clock outputs and sample_ack against the elapsed-cycle reference
  always @(negedge clk) begin
    if (started) begin
      chk("mclk", audio_mclk, cyc[1]);
      chk("sck", audio_sck, cyc[4]);
      chk("lrck", audio_lrck, cyc[9]);
      chk("ack", sample_ack, (cyc % 1024 == 0) && (cyc != 0));
      if (sample_ack) ack_cnt++;
    end
  end

  // data monitor: sample sdin on each sck rising edge and pop the expectation
  always @(negedge clk) begin
    if (started) begin
      if (audio_sck && !sck_prev) begin
        if (q.size() == 0) chk("sdin_underflow", 1, 0);
        else chk("sdin", audio_sdin, q.pop_front());
      end
      sck_prev = audio_sck;
    end
  end

  initial begin
    @(posedge clk);
    started = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_sdin", audio_sdin, 0);
      chk("rst_outs", {audio_mclk, audio_sck, audio_lrck, sample_ack}, 0);
    end
    rst = 1'b1;
    push_frame(1'b0, 32'h0);
    wait_cyc(1024);
    push_frame(1'b0, 32'hA5005A5B);
    wait_cyc(1324);
    audio_left = 16'h1234;
    wait_cyc(2048);
    push_frame(1'b1, 32'h12345A5B);
    wait_cyc(2748);
    enable = 1'b0;
    wait_cyc(3072);
    push_frame(1'b1, 32'h0);
    wait_cyc(4096);
    push_frame(1'b0, 32'h0);
    enable = 1'b1;
    audio_left = 16'hA500;
    wait_cyc(4596);
    chk("ack_count", ack_cnt, 4);
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    chk("midrst_sdin", audio_sdin, 0);
    chk("midrst_outs", {audio_mclk, audio_sck, audio_lrck, sample_ack}, 0);
    rst = 1'b1;
    push_frame(1'b0, 32'h0);
    wait_cyc(1024);
    push_frame(1'b0, 32'hA5005A5B);
    wait_cyc(2048);
    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
